// File: rtl/conv_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module : conv_tile_sequencer
// Loads N weight/activation tiles, runs the core per tile and writes the sum.
// Rev    : 1.0
// ============================================================================
module conv_tile_sequencer #(
  parameter int         WORD_SIZE    = 64,
  parameter int         SRAM_DEPTH   = 64,
  parameter logic [6:0] IDX_SENTINEL = 7'h7F,
  parameter int         RES_WIDTH    = 20,
  parameter int         ACC_WIDTH    = 32,
  parameter int         DONE_TIMEOUT = 4096,
  localparam int        AW           = $clog2(SRAM_DEPTH),
  localparam int        TW           = $clog2(DONE_TIMEOUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_start,
  input  logic [7:0]           cfg_num_tiles,
  input  logic [AW-1:0]        cfg_pe_row,
  input  logic [7:0]           cfg_out_addr,
  output logic                 busy,
  output logic                 cmd_done,
  output logic                 err_timeout,
  output logic                 fetch_req,
  output logic [7:0]           fetch_tile,
  output logic [AW-1:0]        fetch_addr,
  input  logic                 fetch_valid,
  input  logic [7:0]           fetch_idx,
  input  logic [WORD_SIZE-1:0] fetch_val,
  input  logic [WORD_SIZE-1:0] fetch_act,
  output logic                 wr_compressed,
  output logic [AW-1:0]        wr_comp_row,
  output logic [AW-1:0]        wr_comp_idx,
  output logic [AW-1:0]        wr_comp_ptr,
  output logic [WORD_SIZE-1:0] wr_comp_val,
  output logic                 act_wr_en,
  output logic [AW-1:0]        act_wr_addr,
  output logic [WORD_SIZE-1:0] act_wr_data,
  output logic                 acc_start,
  input  logic                 acc_done,
  input  logic [RES_WIDTH-1:0] pe0_result,
  output logic                 out_wr_en,
  output logic [7:0]           out_wr_addr,
  output logic [ACC_WIDTH-1:0] out_wr_data,
  output logic [AW:0]          tile_nz_count,
  output logic [7:0]           tiles_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state;
  logic [7:0]           num_tiles;
  logic [AW:0]          nz;
  logic [TW-1:0]        tmo;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 is_sentinel;
  logic                 last_addr;
  logic                 last_tile;
  logic                 unused_idx_msb;

  assign is_sentinel    = (fetch_idx[6:0] == IDX_SENTINEL);
  assign last_addr      = (fetch_addr == AW'(SRAM_DEPTH - 1));
  assign last_tile      = (fetch_tile == num_tiles - 8'd1);
  assign acc_sum        = acc + {{(ACC_WIDTH-RES_WIDTH){pe0_result[RES_WIDTH-1]}}, pe0_result};
  assign unused_idx_msb = fetch_idx[7];

  // fetch_tile and fetch_addr double as the tile and entry counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      num_tiles     <= '0;
      nz            <= '0;
      tmo           <= '0;
      acc           <= '0;
      busy          <= 1'b0;
      cmd_done      <= 1'b0;
      err_timeout   <= 1'b0;
      fetch_req     <= 1'b0;
      fetch_tile    <= '0;
      fetch_addr    <= '0;
      wr_compressed <= 1'b0;
      wr_comp_row   <= '0;
      wr_comp_idx   <= '0;
      wr_comp_ptr   <= '0;
      wr_comp_val   <= '0;
      act_wr_en     <= 1'b0;
      act_wr_addr   <= '0;
      act_wr_data   <= '0;
      acc_start     <= 1'b0;
      out_wr_en     <= 1'b0;
      out_wr_addr   <= '0;
      out_wr_data   <= '0;
      tile_nz_count <= '0;
      tiles_done    <= '0;
    end else begin
      wr_compressed <= 1'b0;
      act_wr_en     <= 1'b0;
      acc_start     <= 1'b0;
      out_wr_en     <= 1'b0;
      cmd_done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            num_tiles   <= cfg_num_tiles;
            wr_comp_row <= cfg_pe_row;
            out_wr_addr <= cfg_out_addr;
            acc         <= '0;
            tiles_done  <= '0;
            err_timeout <= 1'b0;
            fetch_tile  <= '0;
            busy        <= 1'b1;
            if (cfg_num_tiles == 8'd0) begin
              out_wr_en   <= 1'b1;
              out_wr_data <= '0;
              state       <= S_WRITE;
            end else begin
              fetch_req  <= 1'b1;
              fetch_addr <= '0;
              nz         <= '0;
              state      <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (fetch_valid) begin
            wr_compressed <= 1'b1;
            wr_comp_idx   <= fetch_addr;
            wr_comp_ptr   <= fetch_idx[AW-1:0];
            wr_comp_val   <= is_sentinel ? '0 : fetch_val;
            act_wr_en     <= 1'b1;
            act_wr_addr   <= fetch_addr;
            act_wr_data   <= fetch_act;
            if (!is_sentinel) nz <= nz + (AW+1)'(1);
            if (last_addr) begin
              fetch_req <= 1'b0;
              state     <= S_START;
            end else begin
              fetch_addr <= fetch_addr + AW'(1);
            end
          end
        end
        S_START: begin
          acc_start     <= 1'b1;
          tile_nz_count <= nz;
          tmo           <= '0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (acc_done) begin
            acc        <= acc_sum;
            tiles_done <= tiles_done + 8'd1;
            if (last_tile) begin
              out_wr_en   <= 1'b1;
              out_wr_data <= acc_sum;
              state       <= S_WRITE;
            end else begin
              fetch_tile <= fetch_tile + 8'd1;
              fetch_addr <= '0;
              nz         <= '0;
              fetch_req  <= 1'b1;
              state      <= S_LOAD;
            end
          end else if (tmo == TW'(DONE_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            cmd_done    <= 1'b1;
            state       <= S_DONE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_WRITE: begin
          cmd_done <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/conv_tile_sequencer.md
Name: conv_tile_sequencer

Overview:
- Sequences one output-channel/position reduction across N column tiles of the BNN accelerator core.
- Per tile:
  - fetches 64 compressed weight entries and 64 activation words from the tile buffer;
  - streams the weights over the compressed-write interface and the activations into activation SRAM;
  - pulses acc_start, waits for acc_done, then sign-extends and accumulates the PE0 result.
- After the last tile, writes the 32-bit sum to output SRAM. Replaces manual tile control when ENABLE_LAYER_EXEC=0.

Parameters:
- WORD_SIZE, 64, weight/activation word width
- SRAM_DEPTH, 64, entries per tile; fetch/write address width is log2(SRAM_DEPTH)=6
- IDX_SENTINEL, 7'h7F, compressed-index value marking an empty slot
- RES_WIDTH, 20, per-PE result width, two's complement
- ACC_WIDTH, 32, accumulator/output SRAM width
- DONE_TIMEOUT, 4096, maximum WAIT cycles before abort

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_start  in  1  pulse: begin job; ignored while busy
- cfg_num_tiles  in  8  tiles per job, sampled at cmd_start
- cfg_pe_row  in  6  PE row / output channel, sampled at cmd_start
- cfg_out_addr  in  8  output SRAM address, sampled at cmd_start
- busy  out  1  high from the cycle after an accepted cmd_start until the cmd_done cycle, inclusive
- cmd_done  out  1  one-cycle pulse at job end
- err_timeout  out  1  sticky; cleared by the next accepted cmd_start
- fetch_req  out  1  request a tile-buffer beat
- fetch_tile  out  8  tile number
- fetch_addr  out  6  entry number within the tile
- fetch_valid  in  1  beat accepted; fetch_idx/val/act valid
- fetch_idx  in  8  compressed index (bits [6:0] compared against sentinel)
- fetch_val  in  64  weight word
- fetch_act  in  64  activation word
- wr_compressed  out  1  compressed-write strobe
- wr_comp_row  out  6  equals the latched cfg_pe_row
- wr_comp_idx  out  6  slot number
- wr_comp_ptr  out  6  fetch_idx[5:0]
- wr_comp_val  out  64  weight word, or 0 for a sentinel slot
- act_wr_en  out  1  activation SRAM write
- act_wr_addr  out  6  activation SRAM address
- act_wr_data  out  64  activation word
- acc_start  out  1  one-cycle core start
- acc_done  in  1  core done level/pulse
- pe0_result  in  20  PE0 result, sampled at acc_done
- out_wr_en  out  1  output SRAM write strobe
- out_wr_addr  out  8  equals the latched cfg_out_addr
- out_wr_data  out  32  final sum
- tile_nz_count  out  7  non-sentinel entries in the last loaded tile
- tiles_done  out  8  tiles accumulated in the current job

Behaviour:
- Reset:
  - Asynchronous; state goes to IDLE.
  - All outputs, counters and the accumulator go to 0, including err_timeout.
  - A reset during any state abandons the job; no out_wr_en is issued.
- All outputs are registered.

State machine:
- IDLE:
  - On cmd_start, latch the cfg_* inputs, clear acc/tiles_done/err_timeout, and set tile=0.
  - If cfg_num_tiles=0, go to WRITE (writes 0). Otherwise go to LOAD with addr=0 and nz=0.
- LOAD:
  - fetch_req=1, fetch_tile=tile, fetch_addr=addr.
  - Each cycle with fetch_valid=1 is an accepted beat, and addr increments. fetch_valid=0 stalls with the address held.
  - Beat side effects, all on the next cycle for exactly one cycle:
    - wr_compressed=1, wr_comp_idx=addr, wr_comp_ptr=fetch_idx[5:0];
    - wr_comp_val = fetch_val, or 0 if fetch_idx[6:0]==IDX_SENTINEL;
    - act_wr_en=1, act_wr_addr=addr, act_wr_data=fetch_act.
  - nz increments for each non-sentinel beat.
  - After the beat at addr=63: fetch_req drops and the state goes to START. Address wrap is never used.
- START:
  - acc_start=1 for one cycle, strictly after the final write strobe.
  - tile_nz_count is updated from nz. Go to WAIT with the timeout counter at 0.
- WAIT:
  - On acc_done=1, capture pe0_result, sign-extend it to 32 bits, and add it to acc. Overflow wraps modulo 2^32; no saturation.
  - tiles_done then increments. If tile+1==num_tiles, go to WRITE; else tile++ and go to LOAD.
  - If the timeout counter reaches DONE_TIMEOUT-1 without acc_done: set err_timeout and go to DONE, skipping WRITE.
- WRITE: out_wr_en=1 for one cycle with out_wr_data=acc; go to DONE.
- DONE: cmd_done=1 for one cycle; busy drops in the same cycle it ends; go to IDLE.

Boundary and concurrency rules:
- acc_done seen outside WAIT is ignored.
- cmd_start while busy is ignored.
- cmd_start is accepted in the cycle after DONE.
- A 255-tile job is legal.
- Job latency with fetch_valid held high is N×(64+1+1+Lcore+1)+2 cycles, where Lcore is the acc_start→acc_done delay.

Test Plan:
- 1 tile, fetch_valid=1 constantly, all idx non-sentinel, core returns 5 → exactly 64 wr_compressed and 64 act_wr_en pulses, with slot addresses 0..63 in order; tile_nz_count=64; one out_wr_en with data 0x00000005; cmd_done one cycle later.
- 3 tiles, results 10, 0xFFFFD (−3), 7 → out_wr_data=14, tiles_done=3, fetch_tile sequence 0,1,2.
- Tile with idx=0x7F at slots 0, 31 and 63 → wr_comp_val=0 and wr_comp_ptr=6'h3F at those slots; tile_nz_count=61.
- fetch_valid toggling 1,0,1,0 → fetch_addr holds during stalls; still exactly 64 write pulses with no duplicates; acc_start only after the 64th pulse.
- acc_done never asserted → err_timeout=1 after DONE_TIMEOUT WAIT cycles, no out_wr_en, cmd_done pulses; the next cmd_start clears err_timeout.
- reset asserted mid-LOAD at addr=20 → all outputs 0 immediately; then cfg_num_tiles=0 with cmd_start → out_wr_en with data 0, cmd_done.
